// File: rtl/boa_mem_arbiter_if.sv
// Single-word memory bus shared by the fetch port, the data port and the memory side
// of boa_mem_arbiter.
interface boa_mem_arbiter_if;
  logic        re;
  logic [3:0]  we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output re, we, addr, wdata, input ready, rdata);
  modport slave  (input re, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/boa_mem_arbiter.sv
// Two-master (fetch/data) to one-slave memory arbiter. The grant parks on the last owner.
// BOA_ARB_RR_EN selects round-robin; otherwise data has priority with a MAX_BURST guard.
module boa_mem_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  boa_mem_arbiter_if.slave   p,
  boa_mem_arbiter_if.slave   d,
  boa_mem_arbiter_if.master  m,
  output logic [1:0]         owner
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwnP = 2'd1,
    StOwnD = 2'd2
  } state_e;

  localparam int unsigned BurstW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);

  state_e            state_q, state_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [BurstW-1:0] burst_inc;
  logic              p_req, d_req;

  assign p_req = p.re | (|p.we);
  assign d_req = d.re | (|d.we);

  // Saturating count including the completion happening this cycle.
  assign burst_inc = (burst_q == BurstMax) ? burst_q : burst_q + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (d_req) begin
          state_d = StOwnD;
        end else if (p_req) begin
          state_d = StOwnP;
        end
      end
      StOwnP: begin
        if (!p_req) begin
          if (d_req) state_d = StOwnD;
        end else if (m.ready && d_req) begin
          state_d = StOwnD;
        end
      end
      StOwnD: begin
        if (!d_req) begin
          if (p_req) state_d = StOwnP;
        end else if (m.ready && p_req) begin
`ifdef BOA_ARB_RR_EN
          state_d = StOwnP;
`else
          if (burst_inc == BurstMax) state_d = StOwnP;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
`ifdef BOA_ARB_RR_EN
    burst_d = '0;
`else
    burst_d = burst_q;
    // A data completion with no fetch waiting breaks the consecutive run.
    if (state_q == StOwnD && d_req && m.ready) begin
      burst_d = p_req ? burst_inc : '0;
    end
    if (state_d == StOwnP && state_q != StOwnP) begin
      burst_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // Memory request path is combinational from the registered owner.
  always_comb begin
    m.re    = 1'b0;
    m.we    = '0;
    m.addr  = '0;
    m.wdata = '0;
    unique case (state_q)
      StOwnP: begin
        m.re    = p.re;
        m.we    = p.we;
        m.addr  = p.addr;
        m.wdata = p.wdata;
      end
      StOwnD: begin
        m.re    = d.re;
        m.we    = d.we;
        m.addr  = d.addr;
        m.wdata = d.wdata;
      end
      default: ;
    endcase
  end

  assign p.ready = m.ready & (state_q == StOwnP);
  assign d.ready = m.ready & (state_q == StOwnD);
  assign p.rdata = m.rdata;
  assign d.rdata = m.rdata;
  assign owner   = state_q;

endmodule

// File: doc/boa_mem_arbiter.md
# boa_mem_arbiter

Two-master, one-slave memory arbiter for the Boa³² core. It lets the instruction-fetch port and the data port share a single memory port, so a single-ported SRAM or external bus can back both without a second interface. It sits between the CPU's program/data buses and the shared memory. It parks the grant on the last owner and sequences ownership changes on transaction boundaries, so a grant never changes mid-transaction.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- `MAX_BURST`, default 8: consecutive data-port completions allowed while the fetch port waits; used only in the fixed-priority build.

Ports:
- `clk`  in  1  CPU clock.
- `rst`  in  1  asynchronous, active-low reset.
- `p_re`  in  1  fetch port read request.
- `p_we`  in  4  fetch port byte write enables.
- `p_addr`  in  30  fetch port word address [31:2].
- `p_wdata`  in  32  fetch port write data.
- `p_ready`  out  1  fetch port transaction complete.
- `p_rdata`  out  32  fetch port read data.
- `d_re`, `d_we`, `d_addr`, `d_wdata`  in  1/4/30/32  data port request, same meaning as the `p_` signals.
- `d_ready`, `d_rdata`  out  1/32  data port completion and read data.
- `m_re`, `m_we`, `m_addr`, `m_wdata`  out  1/4/30/32  shared memory request.
- `m_ready`  in  1  shared memory completion.
- `m_rdata`  in  32  shared memory read data.
- `owner`  out  2  current grant: 0 = none, 1 = fetch, 2 = data.

## Operation
- A master requests when `x_re` or any `x_we` bit is set. It holds address, data and enables stable until `x_ready` is 1.
- States:
  - IDLE: no owner; all `m_` outputs are 0.
  - OWN_P: `m_` outputs mirror the fetch port.
  - OWN_D: `m_` outputs mirror the data port.
- Read data routing: `p_rdata` and `d_rdata` always carry `m_rdata`.
- Ready routing: `x_ready = m_ready && (owner == x)`. The non-owner's ready is 0.
- Completion is any cycle in the owning state with an active request and `m_ready` = 1.
- IDLE transitions:
  - To OWN_D if `d` requests, else to OWN_P if `p` requests, else stay.
  - If both request simultaneously, data wins.
- Owning state with the owner not requesting: switch to the other owner next cycle if it is requesting, else park (stay).
- Owning state at a completion: the switch rule is set by Configuration.
- `burst`: counter of consecutive OWN_D completions observed while `p` was requesting.
  - Saturates at `MAX_BURST`.
  - Clears on any transition into OWN_P.
- The grant never changes in a cycle where the owner has a request but no `m_ready`. A stalled slave therefore holds the current owner indefinitely.
- `m_we` and `m_re` are passed through unmodified. The slave resolves the case where both are set.

## Timing
- Reset values:
  - state IDLE, `owner` 0, `burst` 0.
  - All `m_` outputs 0, `p_ready` 0, `d_ready` 0.
  - `x_rdata` follows `m_rdata`.
- Reset asserted mid-transaction aborts it immediately and asynchronously. The master must re-issue the request.
- Request-to-memory latency:
  - 1 cycle from IDLE or from a non-requesting owner: the grant is registered and the `m_` path is combinational from the owner.
  - 0 cycles if the requester already owns the grant (parked).
- Back-to-back transactions by the same owner: no bubble.
- Ownership switch after a completion: the new owner's request appears on `m_` in the next cycle, with no bubble.
- `m_ready` to `x_ready`: combinational, 0 cycles.

## Configuration
- `BOA_ARB_RR_EN` defined: round-robin.
  - At every completion, switch to the other master if it is requesting; otherwise stay.
  - `burst` is unused and held at 0.
- `BOA_ARB_RR_EN` undefined: fixed data priority with starvation guard.
  - OWN_P completion: switch to OWN_D if `d` requests.
  - OWN_D completion: switch to OWN_P only if `p` requests and `burst` equals `MAX_BURST`, counting this completion. Otherwise stay.

## Test plan
- Reset then idle:
  - Stimulus: `rst` low, then high; no requests.
  - Required: `owner` = 0, all `m_` outputs 0. Then `p_re` = 1 with `p_addr` = 0x1000_0000: `m_re` = 1 and `m_addr` = 0x1000_0000 one cycle later.
- Simultaneous first requests:
  - Stimulus: `p_re` and `d_we` = 4'hF in the same cycle from IDLE.
  - Required: `owner` = 2, `m_we` = 4'hF, `d_ready` pulses while `p_ready` stays 0. Then `owner` = 1 after the data completion.
- Slave stall:
  - Stimulus: owner data, `m_ready` held 0 for 5 cycles with `p_re` pending.
  - Required: `owner` stays 2 for all 5 cycles; `p_ready` = 0 throughout.
- Starvation guard (macro undefined, `MAX_BURST` = 3):
  - Stimulus: `d_re` held high with 1-cycle memory, `p_re` held high.
  - Required: exactly 3 `d_ready` pulses, then one `p_ready`, repeating.
- Round-robin (`BOA_ARB_RR_EN` defined):
  - Stimulus: same stimulus as the starvation-guard test.
  - Required: `d_ready` and `p_ready` strictly alternate every cycle.
- Reset mid-transaction:
  - Stimulus: `rst` low while `m_we` = 4'h3 is pending.
  - Required: `m_we` = 0 and `owner` = 0 in the same cycle, with no `d_ready` pulse.
